// File: rtl/pp_pkg.sv
// Shared constants and pipeline-register types for the 16-bit 5-stage processor.
package pp_pkg;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  localparam logic [2:0] OP_LDD = 3'b001;
  localparam logic [2:0] OP_STD = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    word_t instr;
  } if_id_t;

  typedef struct packed {
    logic [2:0] op;
    reg_addr_t  ra;
    reg_addr_t  rb;
    word_t      a;
    word_t      b;
  } id_ex_t;

  typedef struct packed {
    logic      reg_we;
    logic      mem_we;
    logic      mem_rd;
    reg_addr_t dest;
    word_t     alu;
    word_t     store_data;
  } ex_mem_t;

  typedef struct packed {
    logic      reg_we;
    reg_addr_t dest;
    word_t     data;
  } mem_wb_t;
endpackage

// File: rtl/pp_regfile.sv
// 8x16 register file: two operand read ports plus a debug port, all write-through,
// reset to R[i] = i.
module pp_regfile
  import pp_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  input  reg_addr_t dbg_addr,
  output word_t     rd_data_a,
  output word_t     rd_data_b,
  output word_t     dbg_data,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  word_t     wr_data
);
  word_t regs [8];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= word_t'(i);
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // The pending WB write is bypassed so ID sees it in the same cycle.
  assign rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
  assign rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
  assign dbg_data  = (wr_en && wr_addr == dbg_addr)  ? wr_data : regs[dbg_addr];
endmodule

// File: rtl/pipelined_processor.sv
// 16-bit 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with an IMEM loader port.
// Define FORWARDING_EN to add EX operand forwarding from EX/MEM and MEM/WB.
module pipelined_processor
  import pp_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h20,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  write_addr,
  output logic [15:0] result,
  input  logic        write_enable_fm,
  input  logic        rst_fm,
  input  logic [15:0] write_data_fm,
  input  logic [31:0] write_addr_fm,
  output logic [15:0] instruction,
  output logic        mem_write,
  output logic [15:0] show
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  word_t       imem [IMEM_DEPTH];
  word_t       dmem [DMEM_DEPTH];
  logic [31:0] pc;
  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;

  reg_addr_t id_ra, id_rb;
  word_t     id_a, id_b;
  word_t     ex_a, ex_b, ex_alu;
  logic      unused_addr_bits;

  assign unused_addr_bits = ^write_addr_fm[31:IMEM_AW];

  // The loader runs independently of the core reset; a clear beats a write.
  always_ff @(posedge clk) begin
    if (rst_fm) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
    end else if (write_enable_fm) begin
      imem[write_addr_fm[IMEM_AW-1:0]] <= write_data_fm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      if_id <= '0;
    end else begin
      if_id.instr <= imem[pc[IMEM_AW-1:0]];
      pc          <= pc + 32'd1;
    end
  end

  assign id_ra = if_id.instr[12:10];
  assign id_rb = if_id.instr[9:7];

  pp_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (id_ra),
    .rd_addr_b (id_rb),
    .dbg_addr  (write_addr),
    .rd_data_a (id_a),
    .rd_data_b (id_b),
    .dbg_data  (result),
    .wr_en     (mem_wb.reg_we),
    .wr_addr   (mem_wb.dest),
    .wr_data   (mem_wb.data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      id_ex <= '0;
    end else begin
      id_ex <= '{op: if_id.instr[15:13], ra: id_ra, rb: id_rb, a: id_a, b: id_b};
    end
  end

  always_comb begin
    ex_a   = id_ex.a;
    ex_b   = id_ex.b;
    ex_alu = '0;
`ifdef FORWARDING_EN
    // MEM/WB is applied first so the younger EX/MEM producer overrides it;
    // a load in EX/MEM only holds its address, so it is never forwarded.
    if (mem_wb.reg_we && mem_wb.dest == id_ex.ra) ex_a = mem_wb.data;
    if (mem_wb.reg_we && mem_wb.dest == id_ex.rb) ex_b = mem_wb.data;
    if (ex_mem.reg_we && !ex_mem.mem_rd && ex_mem.dest == id_ex.ra) ex_a = ex_mem.alu;
    if (ex_mem.reg_we && !ex_mem.mem_rd && ex_mem.dest == id_ex.rb) ex_b = ex_mem.alu;
`endif
    case (id_ex.op)
      OP_LDD:  ex_alu = ex_a;
      OP_STD:  ex_alu = ex_b;
      OP_ADD:  ex_alu = ex_a + ex_b;
      OP_NOT:  ex_alu = ~ex_a;
      default: ex_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem <= '0;
    end else begin
      ex_mem.reg_we     <= (id_ex.op == OP_LDD) || (id_ex.op == OP_ADD) || (id_ex.op == OP_NOT);
      ex_mem.mem_we     <= (id_ex.op == OP_STD);
      ex_mem.mem_rd     <= (id_ex.op == OP_LDD);
      ex_mem.dest       <= (id_ex.op == OP_NOT) ? id_ex.ra : id_ex.rb;
      ex_mem.alu        <= ex_alu;
      ex_mem.store_data <= ex_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
      mem_wb <= '0;
    end else begin
      if (ex_mem.mem_we) dmem[ex_mem.alu[DMEM_AW-1:0]] <= ex_mem.store_data;
      mem_wb.reg_we <= ex_mem.reg_we;
      mem_wb.dest   <= ex_mem.dest;
      mem_wb.data   <= ex_mem.mem_rd ? dmem[ex_mem.alu[DMEM_AW-1:0]] : ex_mem.alu;
    end
  end

  assign instruction = if_id.instr;
  assign mem_write   = ex_mem.mem_we;
  assign show        = ex_mem.alu;
endmodule

// File: tb/tb_pipelined_processor.sv
// Scoreboard bench for pipelined_processor: stimulus queues expectations, a negedge
// monitor pops and compares them; honours FORWARDING_EN for the hazard case.
module tb_pipelined_processor;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  write_addr;
  logic [15:0] result;
  logic        write_enable_fm;
  logic        rst_fm;
  logic [15:0] write_data_fm;
  logic [31:0] write_addr_fm;
  logic [15:0] instruction;
  logic        mem_write;
  logic [15:0] show;

  localparam int SEL_INSTR  = 0;
  localparam int SEL_SHOW   = 1;
  localparam int SEL_RESULT = 2;
  localparam int SEL_MEMW   = 3;
  localparam int SEL_PEND   = 4;

`ifdef FORWARDING_EN
  localparam logic [15:0] HAZARD_R2 = 16'h0006;
`else
  localparam logic [15:0] HAZARD_R2 = 16'h0004;
`endif

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } obs_t;

  obs_t        obs_q   [$];
  logic [15:0] store_q [$];
  logic [15:0] prog    [8];
  int          n_compared = 0;
  int          n_failed   = 0;

  pipelined_processor dut (
    .clk             (clk),
    .reset           (reset),
    .write_addr      (write_addr),
    .result          (result),
    .write_enable_fm (write_enable_fm),
    .rst_fm          (rst_fm),
    .write_data_fm   (write_data_fm),
    .write_addr_fm   (write_addr_fm),
    .instruction     (instruction),
    .mem_write       (mem_write),
    .show            (show)
  );

  always #5 clk = ~clk;

  // Monitor: every STD reaching MEM must match a queued store address.
  initial begin : monitor
    obs_t        o;
    logic [15:0] act;
    logic [15:0] exp_addr;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        case (o.sel)
          SEL_INSTR:  act = instruction;
          SEL_SHOW:   act = show;
          SEL_RESULT: act = result;
          SEL_MEMW:   act = {15'd0, mem_write};
          default:    act = 16'(store_q.size());
        endcase
        n_compared++;
        if (act !== o.exp) begin
          n_failed++;
          $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", o.name, act, o.exp);
        end
      end
      if (mem_write === 1'b1) begin
        n_compared++;
        if (store_q.size() == 0) begin
          n_failed++;
          $display("[TB] FAIL unexpected_store: mem_write=1 with show=0x%04h, expected no store", show);
        end else begin
          exp_addr = store_q.pop_front();
          if (show !== exp_addr) begin
            n_failed++;
            $display("[TB] FAIL store_addr: got 0x%04h, expected 0x%04h", show, exp_addr);
          end
        end
      end
    end
  end

  task automatic stepClock(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [31:0] a, input logic [15:0] d);
    write_enable_fm = 1'b1;
    write_addr_fm   = a;
    write_data_fm   = d;
    stepClock();
    write_enable_fm = 1'b0;
  endtask

  // Clears IMEM, loads prog at 0x20 and returns with reset still asserted.
  task automatic applyStimulus(input logic [15:0] p [8]);
    reset  = 1'b1;
    rst_fm = 1'b1;
    stepClock();
    rst_fm = 1'b0;
    for (int i = 0; i < 8; i++) loadWord(32'h20 + 32'(i), p[i]);
    stepClock();
  endtask

  task automatic checkOutput(input string name, input int sel, input logic [2:0] r,
                             input logic [15:0] exp);
    obs_t o;
    o.name = name;
    o.sel  = sel;
    o.exp  = exp;
    if (sel == SEL_RESULT) write_addr = r;
    obs_q.push_back(o);
  endtask

  task automatic checkReg(input string name, input logic [2:0] r, input logic [15:0] exp);
    checkOutput(name, SEL_RESULT, r, exp);
    settle();
  endtask

  initial begin
    reset = 1'b1;
    rst_fm = 1'b0;
    write_enable_fm = 1'b0;
    write_data_fm = '0;
    write_addr_fm = '0;
    write_addr = '0;

    $display("[TB] test 1: loader, reset state, store/load, latency");
    prog = '{16'h453F, 16'h0000, 16'h0000, 16'h0000, 16'h2BBF, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(prog);
    store_q.push_back(16'h0002);
    checkOutput("reset_instr", SEL_INSTR, 3'd0, 16'h0000);
    checkOutput("reset_show", SEL_SHOW, 3'd0, 16'h0000);
    checkOutput("reset_memw", SEL_MEMW, 3'd0, 16'h0000);
    settle();
    for (int i = 0; i < 8; i++) checkReg($sformatf("reset_r%0d", i), 3'(i), 16'(i));
    reset = 1'b0;
    stepClock();
    checkOutput("instr_after_e1", SEL_INSTR, 3'd0, 16'h453F);
    settle();
    stepClock();
    checkOutput("instr_after_e2", SEL_INSTR, 3'd0, 16'h0000);
    settle();
    stepClock();
    checkOutput("show_after_e3", SEL_SHOW, 3'd0, 16'h0002);
    checkOutput("memw_after_e3", SEL_MEMW, 3'd0, 16'h0001);
    settle();
    stepClock();
    checkOutput("memw_after_e4", SEL_MEMW, 3'd0, 16'h0000);
    settle();
    stepClock();
    checkOutput("instr_ldd", SEL_INSTR, 3'd0, 16'h2BBF);
    settle();
    stepClock(7);
    checkReg("ldd_r7", 3'd7, 16'h0001);
    checkReg("ldd_r2", 3'd2, 16'h0002);
    checkOutput("stores_pending", SEL_PEND, 3'd0, 16'h0000);
    settle();

    $display("[TB] test 2: ADD / NOT and writeback timing");
    prog = '{16'h653F, 16'h0000, 16'h0000, 16'h0000, 16'h8C3D, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(prog);
    reset = 1'b0;
    stepClock(3);
    checkReg("add_r2_e3", 3'd2, 16'h0002);
    stepClock();
    checkReg("add_r2_e4_wt", 3'd2, 16'h0003);
    stepClock();
    checkReg("add_r2_e5", 3'd2, 16'h0003);
    stepClock(6);
    checkReg("not_r3", 3'd3, 16'hFFFC);
    checkReg("add_r1", 3'd1, 16'h0001);

    $display("[TB] test 3: back-to-back hazard");
    prog = '{16'h653F, 16'h693F, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(prog);
    reset = 1'b0;
    stepClock(10);
    checkReg("hazard_r2", 3'd2, HAZARD_R2);
    checkReg("hazard_r1", 3'd1, 16'h0001);

    $display("[TB] test 4: wrap and opcode 110");
    prog = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h6080, 16'hDFFF, 16'h0000, 16'h0000};
    applyStimulus(prog);
    reset = 1'b0;
    stepClock(12);
    checkReg("wrap_r0", 3'd0, 16'hFFFF);
    checkReg("wrap_r1", 3'd1, 16'h0000);
    checkReg("op110_r7", 3'd7, 16'h0007);
    checkReg("op110_r6", 3'd6, 16'h0006);

    $display("[TB] test 5: reset mid-program");
    prog = '{16'h9000, 16'h9400, 16'h9800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(prog);
    reset = 1'b0;
    stepClock(4);
    reset = 1'b1;
    stepClock();
    checkOutput("flush_instr", SEL_INSTR, 3'd0, 16'h0000);
    checkOutput("flush_show", SEL_SHOW, 3'd0, 16'h0000);
    checkOutput("flush_memw", SEL_MEMW, 3'd0, 16'h0000);
    settle();
    for (int i = 0; i < 8; i++) checkReg($sformatf("flush_r%0d", i), 3'(i), 16'(i));
    reset = 1'b0;
    stepClock();
    checkOutput("restart_instr", SEL_INSTR, 3'd0, 16'h9000);
    settle();
    stepClock(10);
    checkReg("restart_r4", 3'd4, 16'hFFFB);
    checkReg("restart_r6", 3'd6, 16'hFFF9);

    $display("[TB] test 6: rst_fm beats write_enable_fm");
    reset = 1'b1;
    loadWord(32'h20, 16'h8C3D);
    rst_fm          = 1'b1;
    write_enable_fm = 1'b1;
    write_addr_fm   = 32'h20;
    write_data_fm   = 16'h8C3D;
    stepClock();
    rst_fm          = 1'b0;
    write_enable_fm = 1'b0;
    stepClock();
    reset = 1'b0;
    stepClock();
    checkOutput("clr_priority_instr", SEL_INSTR, 3'd0, 16'h0000);
    settle();
    stepClock(8);
    checkReg("clr_priority_r3", 3'd3, 16'h0003);

    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end
endmodule
